// File: rtl/b_router_pkg.sv
// Shared types and constants for the AXI B-channel response router.
package b_router_pkg;

    localparam int unsigned DATA_W  = 10;
    localparam int unsigned SID_W   = 8;
    localparam int unsigned MID_W   = 4;
    localparam int unsigned NUM_MST = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [3:0] mst;
        logic [3:0] id;
        logic [1:0] resp;
    } b_rec_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;

endpackage

// File: rtl/b_skid2.sv
// Generic 2-entry registered skid buffer; the head record drives the outputs directly from a register.
module b_skid2
    import b_router_pkg::*;
#(
    parameter int unsigned W = $bits(b_rec_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         push_ready,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    input  logic         pop
);

    buf_state_e   state, state_next;
    logic [W-1:0] head_q, head_next;
    logic [W-1:0] tail_q, tail_next;
    logic         ready_q, valid_q;
    logic         push;

    assign push       = push_valid & ready_q;
    assign push_ready = ready_q;
    assign head_valid = valid_q;
    assign head_data  = head_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            head_q  <= head_next;
            tail_q  <= tail_next;
            ready_q <= (state_next != TWO);
            valid_q <= (state_next != EMPTY);
        end
    end

    // Occupancy transitions; pop is ignored while empty, push is impossible while full.
    always_comb begin
        state_next = state;
        head_next  = head_q;
        tail_next  = tail_q;
        case (state)
            EMPTY: begin
                if (push) begin
                    head_next  = push_data;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    tail_next  = push_data;
                    state_next = TWO;
                end else if (!push && pop) begin
                    state_next = EMPTY;
                end else if (push && pop) begin
                    head_next  = push_data;
                end
            end
            TWO: begin
                if (pop) begin
                    head_next  = tail_q;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

endmodule

// File: rtl/b_resp_router.sv
// Routes buffered B-channel records to one of two masters by bid[7:4], stripping the index.
// Optional error counter enabled by defining B_ROUTER_ERR_CNT_EN.
module b_resp_router
    import b_router_pkg::*;
(
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              fifo_valid_i,
    input  logic [DATA_W-1:0] fifo_rdata_i,
    output logic              fifo_ready_o,
    output logic              m0_bvalid_o,
    output logic [MID_W-1:0]  m0_bid_o,
    output logic [1:0]        m0_bresp_o,
    input  logic              m0_bready_i,
    output logic              m1_bvalid_o,
    output logic [MID_W-1:0]  m1_bid_o,
    output logic [1:0]        m1_bresp_o,
    input  logic              m1_bready_i,
`ifdef B_ROUTER_ERR_CNT_EN
    input  logic              err_clr_i,
    output logic [15:0]       err_cnt_o,
`endif
    output logic              drop_o
);

    logic                  head_valid;
    logic [DATA_W-1:0]     head_data;
    b_rec_t                rec;
    logic                  pop;
    logic                  sel0, sel1, bad_idx, delivered;

    b_skid2 #(.W(DATA_W)) u_skid (
        .clk        (rclk),
        .rst_n      (rrst_n),
        .push_valid (fifo_valid_i),
        .push_data  (fifo_rdata_i),
        .push_ready (fifo_ready_o),
        .head_valid (head_valid),
        .head_data  (head_data),
        .pop        (pop)
    );

    assign rec     = b_rec_t'(head_data);
    assign sel0    = (rec.mst == 4'(0));
    assign sel1    = (rec.mst == 4'(1));
    assign bad_idx = (rec.mst >= 4'(NUM_MST));

    // Outputs come only from the head register, never from the FIFO side.
    assign m0_bvalid_o = head_valid & sel0;
    assign m1_bvalid_o = head_valid & sel1;
    assign m0_bid_o    = rec.id;
    assign m1_bid_o    = rec.id;
    assign m0_bresp_o  = rec.resp;
    assign m1_bresp_o  = rec.resp;
    assign drop_o      = head_valid & bad_idx;

    assign delivered = (m0_bvalid_o & m0_bready_i) | (m1_bvalid_o & m1_bready_i);
    assign pop       = delivered | drop_o;

`ifdef B_ROUTER_ERR_CNT_EN
    logic err_evt;
    assign err_evt = (delivered & rec.resp[1]) | drop_o;

    // Saturating error counter; clear wins over a same-cycle event.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            err_cnt_o <= 16'h0000;
        end else if (err_clr_i) begin
            err_cnt_o <= 16'h0000;
        end else if (err_evt && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_b_resp_router.sv
// Scoreboard bench for b_resp_router: random and directed records, queue-based reference model.
module tb_b_resp_router;
    import b_router_pkg::*;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       fifo_valid;
    logic [9:0] fifo_rdata;
    logic       fifo_ready;
    logic       m0_bvalid, m1_bvalid, m0_bready, m1_bready, drop;
    logic [3:0] m0_bid, m1_bid;
    logic [1:0] m0_bresp, m1_bresp;
`ifdef B_ROUTER_ERR_CNT_EN
    logic        err_clr;
    logic [15:0] err_cnt;
    int unsigned err_exp = 0;
`endif

    int checks = 0;
    int failures = 0;

    b_rec_t q[$];
    b_rec_t stim[$];
    bit run = 0;
    bit pushed_now = 0;
    bit hold = 0;
    int p_valid = 0;
    int p0 = 100;
    int p1 = 100;
    int p_clr = 0;

    b_resp_router dut (
        .rclk         (rclk),
        .rrst_n       (rrst_n),
        .fifo_valid_i (fifo_valid),
        .fifo_rdata_i (fifo_rdata),
        .fifo_ready_o (fifo_ready),
        .m0_bvalid_o  (m0_bvalid),
        .m0_bid_o     (m0_bid),
        .m0_bresp_o   (m0_bresp),
        .m0_bready_i  (m0_bready),
        .m1_bvalid_o  (m1_bvalid),
        .m1_bid_o     (m1_bid),
        .m1_bresp_o   (m1_bresp),
        .m1_bready_i  (m1_bready),
`ifdef B_ROUTER_ERR_CNT_EN
        .err_clr_i    (err_clr),
        .err_cnt_o    (err_cnt),
`endif
        .drop_o       (drop)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic b_rec_t rand_rec();
        int unsigned r;
        logic [3:0] m;
        r = $urandom_range(0, 9);
        if (r < 4) m = 4'd0;
        else if (r < 8) m = 4'd1;
        else m = 4'($urandom_range(2, 15));
        return '{mst: m, id: 4'($urandom), resp: 2'($urandom)};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_ready"}, 32'(fifo_ready), 0);
        check({tag, "_m0_bvalid"}, 32'(m0_bvalid), 0);
        check({tag, "_m1_bvalid"}, 32'(m1_bvalid), 0);
        check({tag, "_drop"}, 32'(drop), 0);
        check({tag, "_bid_bresp"}, 32'({m0_bid, m0_bresp, m1_bid, m1_bresp}), 0);
`ifdef B_ROUTER_ERR_CNT_EN
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
`endif
    endtask

    // Driver: FIFO side and master readies, pushes accepted records to the scoreboard.
    initial begin
        fifo_valid = 1'b0;
        fifo_rdata = '0;
        m0_bready  = 1'b0;
        m1_bready  = 1'b0;
`ifdef B_ROUTER_ERR_CNT_EN
        err_clr    = 1'b0;
`endif
        forever begin
            @(negedge rclk);
            if (!run) begin
                fifo_valid = 1'b0;
                hold       = 0;
                pushed_now = 0;
`ifdef B_ROUTER_ERR_CNT_EN
                err_clr    = 1'b0;
`endif
                continue;
            end
            m0_bready = ($urandom_range(0, 99) < p0);
            m1_bready = ($urandom_range(0, 99) < p1);
            if (!hold) begin
                if (stim.size() > 0) begin
                    fifo_valid = 1'b1;
                    fifo_rdata = stim.pop_front();
                end else if ($urandom_range(0, 99) < p_valid) begin
                    fifo_valid = 1'b1;
                    fifo_rdata = rand_rec();
                end else begin
                    fifo_valid = 1'b0;
                end
            end
`ifdef B_ROUTER_ERR_CNT_EN
            err_clr = ($urandom_range(0, 99) < p_clr);
`endif
            #1;
            if (fifo_valid && fifo_ready) begin
                q.push_back(b_rec_t'(fifo_rdata));
                pushed_now = 1;
                hold       = 0;
            end else begin
                pushed_now = 0;
                hold       = fifo_valid;
            end
        end
    end

    // Monitor: records already inside the DUT are q minus the one accepted this cycle.
    initial begin
        int occ;
        bit seen, delivered, dropped;
        b_rec_t e;
        forever begin
            @(negedge rclk);
            #2;
            if (!run) continue;
            occ = q.size() - int'(pushed_now);
            delivered = 0;
            dropped = 0;
            e = '0;
            check("fifo_ready", 32'(fifo_ready), 32'(occ < 2));
            seen = m0_bvalid | m1_bvalid | drop;
            check("head_present", 32'(seen), 32'(occ > 0));
            if (occ > 0) begin
                e = q[0];
                if (e.mst == 4'd0) begin
                    check("m0_route", 32'({m0_bvalid, m1_bvalid, drop}), 32'b100);
                    check("m0_payload", 32'({m0_bid, m0_bresp}), 32'({e.id, e.resp}));
                    if (m0_bready) begin
                        void'(q.pop_front());
                        delivered = 1;
                    end
                end else if (e.mst == 4'd1) begin
                    check("m1_route", 32'({m0_bvalid, m1_bvalid, drop}), 32'b010);
                    check("m1_payload", 32'({m1_bid, m1_bresp}), 32'({e.id, e.resp}));
                    if (m1_bready) begin
                        void'(q.pop_front());
                        delivered = 1;
                    end
                end else begin
                    check("drop_route", 32'({m0_bvalid, m1_bvalid, drop}), 32'b001);
                    void'(q.pop_front());
                    dropped = 1;
                end
            end
`ifdef B_ROUTER_ERR_CNT_EN
            check("err_cnt", 32'(err_cnt), err_exp);
            if (err_clr) err_exp = 0;
            else if (((delivered && e.resp[1]) || dropped) && err_exp < 32'hFFFF) err_exp++;
`else
            if (delivered && dropped) check("deliver_and_drop", 1, 0);
`endif
        end
    end

    initial begin
        rrst_n = 1'b0;
        #3;
        check_all_zero("reset");
        @(negedge rclk);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        check("ready_after_reset", 32'(fifo_ready), 1);
        run = 1;

        // First record, an invalid index, then a following record.
        stim.push_back(b_rec_t'({8'h04, RESP_OKAY}));
        stim.push_back(b_rec_t'({8'h25, RESP_OKAY}));
        stim.push_back(b_rec_t'({8'h13, RESP_SLVERR}));
        repeat (8) @(negedge rclk);

        // Back-to-back alternating masters.
        for (int i = 0; i < 8; i++)
            stim.push_back('{mst: 4'(i % 2), id: 4'(i), resp: RESP_EXOKAY});
        repeat (12) @(negedge rclk);

        // Master 1 stalled while three of its records arrive, then released.
        p1 = 0;
        for (int i = 1; i <= 3; i++)
            stim.push_back('{mst: 4'd1, id: 4'(i), resp: RESP_OKAY});
        repeat (6) @(negedge rclk);
        p1 = 100;
        repeat (6) @(negedge rclk);

`ifdef B_ROUTER_ERR_CNT_EN
        p_clr = 100;
        @(negedge rclk);
        p_clr = 0;
        for (int i = 0; i < 3; i++)
            stim.push_back('{mst: 4'(i % 2), id: 4'(i), resp: RESP_SLVERR});
        stim.push_back('{mst: 4'd7, id: 4'd1, resp: RESP_OKAY});
        repeat (8) @(negedge rclk);
        #3;
        check("err_cnt_four", 32'(err_cnt), 4);
        p_clr = 100;
        repeat (2) @(negedge rclk);
        p_clr = 0;
        #3;
        check("err_cnt_cleared", 32'(err_cnt), 0);
`endif

        // Randomized traffic with varied load and backpressure.
        for (int k = 0; k < 4; k++) begin
            p_valid = 40 + 20 * k;
            p0 = (k == 1) ? 30 : 50 + 15 * k;
            p1 = (k == 2) ? 20 : 100 - 10 * k;
            p_clr = 2;
            repeat (400) @(negedge rclk);
        end
        p_clr = 0;

        // Asynchronous reset in the middle of a busy stream.
        p_valid = 100;
        p0 = 100;
        p1 = 100;
        repeat (5) @(negedge rclk);
        #3;
        run = 0;
        rrst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        q.delete();
        stim.delete();
`ifdef B_ROUTER_ERR_CNT_EN
        err_exp = 0;
`endif
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        run = 1;
        repeat (100) @(negedge rclk);

        // Drain with a bounded wait.
        p_valid = 0;
        p0 = 100;
        p1 = 100;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge rclk);
        check("drain", 32'(q.size()), 0);
        run = 0;
        @(negedge rclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
